// File: rtl/cfg_discovery_pkg.sv
// rtl/cfg_discovery_pkg.sv - word-table layout and builder for the configuration discovery responder
// Purpose: magic constant, word indices, feature-bit positions, dump FSM state
//          enum, and the function that encodes a cva6_cfg_t into the word table.
// Macro:   CFG_DISC_REGION_TABLE_EN appends the region {base, length} pairs.
// Ports:   none (package).
package cfg_discovery_pkg;

  localparam logic [31:0] Magic = 32'hC7A6_0001;

  localparam int unsigned IdxMagic   = 0;
  localparam int unsigned IdxXlen    = 1;
  localparam int unsigned IdxFeat    = 2;
  localparam int unsigned IdxQueues  = 3;
  localparam int unsigned IdxBpred   = 4;
  localparam int unsigned IdxAxi     = 5;
  localparam int unsigned IdxHalt    = 6;
  localparam int unsigned IdxExc     = 7;
  localparam int unsigned IdxDmBase  = 8;
  localparam int unsigned IdxRuleCnt = 9;
  localparam int unsigned FixedWords = 10;

  localparam int unsigned FeatRva    = 0;
  localparam int unsigned FeatRvc    = 1;
  localparam int unsigned FeatRvzcb  = 2;
  localparam int unsigned FeatFpu    = 3;
  localparam int unsigned FeatRvv    = 4;
  localparam int unsigned FeatCvxif  = 5;
  localparam int unsigned FeatZicond = 6;
  localparam int unsigned FeatMmu    = 7;

  // The dump index is 5 bits, so the table can never exceed 32 words;
  // region pairs that would not fit ahead of the checksum are dropped.
  localparam int unsigned IdxW     = 5;
  localparam int unsigned MaxWords = 32;
  localparam int unsigned MaxPairs = (MaxWords - 1 - FixedWords) / 2;

  typedef enum logic {
    DumpIdle   = 1'b0,
    DumpStream = 1'b1
  } dump_state_e;

  function automatic int unsigned num_pairs(cva6_config_pkg::cva6_cfg_t cfg);
`ifdef CFG_DISC_REGION_TABLE_EN
    int unsigned total;
    total = cfg.NrExecuteRegionRules + cfg.NrNonIdempotentRules + cfg.NrCachedRegionRules;
    return (total > MaxPairs) ? MaxPairs : total;
`else
    return (cfg.XLEN == 0) ? 0 : 0;
`endif
  endfunction

  function automatic int unsigned num_words(cva6_config_pkg::cva6_cfg_t cfg);
    return FixedWords + 2 * num_pairs(cfg) + 1;
  endfunction

  function automatic logic [MaxWords-1:0][31:0] build_table(cva6_config_pkg::cva6_cfg_t cfg);
    logic [MaxWords-1:0][31:0] t;
    logic [31:0]               csum;
    int unsigned               cidx;
    t = '0;
    t[IdxMagic] = Magic;
    t[IdxXlen]  = cfg.XLEN;
    t[IdxFeat][FeatRva]    = cfg.RVA;
    t[IdxFeat][FeatRvc]    = cfg.RVC;
    t[IdxFeat][FeatRvzcb]  = cfg.RVZCB;
    t[IdxFeat][FeatFpu]    = cfg.FpuEn;
    t[IdxFeat][FeatRvv]    = cfg.RVV;
    t[IdxFeat][FeatCvxif]  = cfg.CvxifEn;
    t[IdxFeat][FeatZicond] = cfg.ZiCondExtEn;
    t[IdxFeat][FeatMmu]    = cfg.MmuPresent;
    t[IdxQueues]  = {cfg.NrPMPEntries[7:0], cfg.MaxOutstandingStores[7:0],
                     cfg.NrLoadBufEntries[7:0], cfg.NrCommitPorts[7:0]};
    t[IdxBpred]   = {cfg.BHTEntries[15:0], cfg.BTBEntries[7:0], cfg.RASDepth[7:0]};
    t[IdxAxi]     = {cfg.AxiIdWidth[7:0], cfg.AxiDataWidth[7:0],
                     cfg.AxiAddrWidth[7:0], cfg.NOCType[7:0]};
    t[IdxHalt]    = cfg.HaltAddress[31:0];
    t[IdxExc]     = cfg.ExceptionAddress[31:0];
    t[IdxDmBase]  = cfg.DmBaseAddress[31:0];
    t[IdxRuleCnt] = {8'h00, cfg.NrCachedRegionRules[7:0], cfg.NrExecuteRegionRules[7:0],
                     cfg.NrNonIdempotentRules[7:0]};
`ifdef CFG_DISC_REGION_TABLE_EN
    begin
      int unsigned n;
      int unsigned p;
      n = FixedWords;
      p = 0;
      for (int unsigned i = 0; i < cva6_config_pkg::NrMaxRules; i++) begin
        if (i < cfg.NrExecuteRegionRules && p < num_pairs(cfg)) begin
          t[IdxW'(n)]     = cfg.ExecuteRegionAddrBase[i[3:0]][31:0];
          t[IdxW'(n + 1)] = cfg.ExecuteRegionLength[i[3:0]][31:0];
          n = n + 2;
          p = p + 1;
        end
      end
      for (int unsigned i = 0; i < cva6_config_pkg::NrMaxRules; i++) begin
        if (i < cfg.NrNonIdempotentRules && p < num_pairs(cfg)) begin
          t[IdxW'(n)]     = cfg.NonIdempotentAddrBase[i[3:0]][31:0];
          t[IdxW'(n + 1)] = cfg.NonIdempotentLength[i[3:0]][31:0];
          n = n + 2;
          p = p + 1;
        end
      end
      for (int unsigned i = 0; i < cva6_config_pkg::NrMaxRules; i++) begin
        if (i < cfg.NrCachedRegionRules && p < num_pairs(cfg)) begin
          t[IdxW'(n)]     = cfg.CachedRegionAddrBase[i[3:0]][31:0];
          t[IdxW'(n + 1)] = cfg.CachedRegionLength[i[3:0]][31:0];
          n = n + 2;
          p = p + 1;
        end
      end
    end
`endif
    // Unwritten slots are zero, so XOR over the whole prefix is the checksum.
    cidx = num_words(cfg) - 1;
    csum = '0;
    for (int unsigned i = 0; i < MaxWords; i++) begin
      if (i < cidx) csum = csum ^ t[i];
    end
    t[IdxW'(cidx)] = csum;
    return t;
  endfunction

endpackage

// File: rtl/cva6_config_pkg.sv
// rtl/cva6_config_pkg.sv - CVA6 configuration record and the default elaborated configuration
// Purpose: configuration record consumed by cfg_discovery_responder, plus the
//          default value cva6_cfg (RV32 application-class core).
// Ports:   none (package).
package cva6_config_pkg;

  localparam int unsigned NrMaxRules = 16;
  localparam int unsigned RuleIdxW   = 4;

  typedef struct packed {
    int unsigned                   XLEN;
    logic                          RVA;
    logic                          RVC;
    logic                          RVZCB;
    logic                          FpuEn;
    logic                          RVV;
    logic                          CvxifEn;
    logic                          ZiCondExtEn;
    logic                          MmuPresent;
    int unsigned                   NrPMPEntries;
    int unsigned                   MaxOutstandingStores;
    int unsigned                   NrLoadBufEntries;
    int unsigned                   NrCommitPorts;
    int unsigned                   BHTEntries;
    int unsigned                   BTBEntries;
    int unsigned                   RASDepth;
    int unsigned                   AxiIdWidth;
    int unsigned                   AxiDataWidth;
    int unsigned                   AxiAddrWidth;
    int unsigned                   NOCType;
    logic [63:0]                   HaltAddress;
    logic [63:0]                   ExceptionAddress;
    logic [63:0]                   DmBaseAddress;
    int unsigned                   NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]   NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]   NonIdempotentLength;
    int unsigned                   NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]   ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]   ExecuteRegionLength;
    int unsigned                   NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]   CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]   CachedRegionLength;
  } cva6_cfg_t;

  function automatic cva6_cfg_t default_cfg();
    cva6_cfg_t c;
    c = '0;
    c.XLEN                 = 32;
    c.RVA                  = 1'b1;
    c.RVC                  = 1'b1;
    c.MmuPresent           = 1'b1;
    c.NrPMPEntries         = 8;
    c.MaxOutstandingStores = 7;
    c.NrLoadBufEntries     = 2;
    c.NrCommitPorts        = 2;
    c.BHTEntries           = 128;
    c.BTBEntries           = 32;
    c.RASDepth             = 2;
    c.AxiIdWidth           = 4;
    c.AxiDataWidth         = 64;
    c.AxiAddrWidth         = 64;
    c.NOCType              = 0;
    c.HaltAddress          = 64'h800;
    c.ExceptionAddress     = 64'h808;
    c.DmBaseAddress        = 64'h0;
    c.NrExecuteRegionRules = 3;
    c.ExecuteRegionAddrBase[0] = 64'h0000_0000;
    c.ExecuteRegionLength[0]   = 64'h0000_1000;
    c.ExecuteRegionAddrBase[1] = 64'h0001_0000;
    c.ExecuteRegionLength[1]   = 64'h0001_0000;
    c.ExecuteRegionAddrBase[2] = 64'h8000_0000;
    c.ExecuteRegionLength[2]   = 64'h4000_0000;
    c.NrNonIdempotentRules = 2;
    c.NonIdempotentAddrBase[0] = 64'h0200_0000;
    c.NonIdempotentLength[0]   = 64'h000C_0000;
    c.NonIdempotentAddrBase[1] = 64'h0C00_0000;
    c.NonIdempotentLength[1]   = 64'h0400_0000;
    c.NrCachedRegionRules  = 1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    return c;
  endfunction

  localparam cva6_cfg_t cva6_cfg = default_cfg();

endpackage

// File: rtl/cfg_discovery_responder_if.sv
// rtl/cfg_discovery_responder_if.sv - load port and dump stream bundle of the discovery responder
// Purpose: groups the req/gnt + rvalid/rready load port and the dump stream.
// Ports:   slave modport = responder side, master modport = requester/sink side.
interface cfg_discovery_responder_if #(
  parameter int unsigned AddrWidth = 8
);
  logic                 req_i;
  logic                 gnt_o;
  logic [AddrWidth-1:0] addr_i;
  logic                 we_i;
  logic                 rvalid_o;
  logic [31:0]          rdata_o;
  logic                 rerr_o;
  logic                 rready_i;
  logic                 dump_start_i;
  logic                 dump_valid_o;
  logic [31:0]          dump_data_o;
  logic                 dump_last_o;
  logic                 dump_ready_i;
  logic                 dump_busy_o;

  modport slave (
    input  req_i, addr_i, we_i, rready_i, dump_start_i, dump_ready_i,
    output gnt_o, rvalid_o, rdata_o, rerr_o, dump_valid_o, dump_data_o, dump_last_o, dump_busy_o
  );

  modport master (
    output req_i, addr_i, we_i, rready_i, dump_start_i, dump_ready_i,
    input  gnt_o, rvalid_o, rdata_o, rerr_o, dump_valid_o, dump_data_o, dump_last_o, dump_busy_o
  );
endinterface

// File: rtl/cfg_discovery_resp_fifo.sv
// rtl/cfg_discovery_resp_fifo.sv - in-order response buffer for the discovery load port
// Purpose: Depth-entry FIFO; output data reads zero while empty.
// Ports:   clk_i/rst_i; push_i/push_data_i/full_o write side;
//          pop_i/valid_o/data_o read side.
module cfg_discovery_resp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign valid_o = (count_q != '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;
  assign data_o  = valid_o ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/cfg_discovery_responder.sv
// rtl/cfg_discovery_responder.sv - read-only responder exposing the CVA6 configuration word table
// Purpose: serves the encoded configuration table on a load port and streams
//          the whole table on request.
// Macro:   CFG_DISC_REGION_TABLE_EN (region pairs in the table, see package).
// Ports:   clk_i, rst_i (async, active-high);
//          bus (slave): req_i/gnt_o/addr_i/we_i, rvalid_o/rdata_o/rerr_o/rready_i,
//          dump_start_i, dump_valid_o/dump_data_o/dump_last_o/dump_ready_i, dump_busy_o.
module cfg_discovery_responder
  import cfg_discovery_pkg::*;
#(
  parameter cva6_config_pkg::cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg,
  parameter int unsigned RespFifoDepth = 2,
  parameter int unsigned AddrWidth     = 8
) (
  input logic                      clk_i,
  input logic                      rst_i,
  cfg_discovery_responder_if.slave bus
);
  localparam logic [MaxWords-1:0][31:0] Table = build_table(CVA6Cfg);
  localparam int unsigned               NumWords = num_words(CVA6Cfg);
  localparam logic [IdxW-1:0]           LastIdx  = IdxW'(NumWords - 1);

  // Load port
  logic [AddrWidth-3:0] word_idx;
  logic                 req_err;
  logic [32:0]          push_data;
  logic [32:0]          head;
  logic                 fifo_full;
  logic                 fifo_valid;

  assign word_idx  = bus.addr_i[AddrWidth-1:2];
  assign req_err   = bus.we_i || (bus.addr_i[1:0] != 2'b00) || (32'(word_idx) >= NumWords);
  assign push_data = req_err ? {1'b1, 32'h0} : {1'b0, Table[word_idx[IdxW-1:0]]};
  assign bus.gnt_o = bus.req_i && !fifo_full;

  cfg_discovery_resp_fifo #(
    .Depth (RespFifoDepth),
    .Width (33)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (bus.gnt_o),
    .push_data_i (push_data),
    .full_o      (fifo_full),
    .pop_i       (bus.rready_i),
    .valid_o     (fifo_valid),
    .data_o      (head)
  );

  assign bus.rvalid_o = fifo_valid;
  assign bus.rerr_o   = head[32];
  assign bus.rdata_o  = head[31:0];

  // Dump stream
  dump_state_e     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            dump_valid;
  logic            dump_last;
  logic [31:0]     dump_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DumpIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    dump_data  = '0;
    unique case (state_q)
      DumpIdle: begin
        if (bus.dump_start_i) begin
          state_d = DumpStream;
          idx_d   = '0;
        end
      end
      DumpStream: begin
        dump_valid = 1'b1;
        dump_last  = (idx_q == LastIdx);
        dump_data  = Table[idx_q];
        if (bus.dump_ready_i) begin
          if (dump_last) begin
            state_d = DumpIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = DumpIdle;
    endcase
  end

  assign bus.dump_valid_o = dump_valid;
  assign bus.dump_last_o  = dump_last;
  assign bus.dump_data_o  = dump_data;
  assign bus.dump_busy_o  = dump_valid;
endmodule

// File: tb/tb_cfg_discovery_responder.sv
// tb/tb_cfg_discovery_responder.sv - directed self-checking bench for cfg_discovery_responder
module tb_cfg_discovery_responder;
`ifdef CFG_DISC_REGION_TABLE_EN
  localparam int NW = 23;
`else
  localparam int NW = 11;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_w [23];

  cfg_discovery_responder_if #(.AddrWidth(8)) bus ();

  cfg_discovery_responder #(
    .RespFifoDepth (2),
    .AddrWidth     (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends at posedge+1; rready_i is expected high.
  task automatic do_read(input string tag, input logic [7:0] a, input logic w,
                         input logic [31:0] ed, input logic ee);
    bus.req_i  = 1'b1;
    bus.addr_i = a;
    bus.we_i   = w;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(bus.gnt_o), 32'd1);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid"}, 32'(bus.rvalid_o), 32'd1);
    chk({tag, "_rdata"}, bus.rdata_o, ed);
    chk({tag, "_rerr"}, 32'(bus.rerr_o), 32'(ee));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_drained"}, 32'(bus.rvalid_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          k;
    int          cyc;
    logic [31:0] xacc;

    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    bus.req_i        = 1'b0;
    bus.addr_i       = '0;
    bus.we_i         = 1'b0;
    bus.rready_i     = 1'b0;
    bus.dump_start_i = 1'b0;
    bus.dump_ready_i = 1'b0;

    for (int i = 0; i < 23; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'hC7A6_0001;
    exp_w[1] = 32'h0000_0020;
    exp_w[2] = 32'h0000_0083;
    exp_w[3] = 32'h0807_0202;
    exp_w[4] = 32'h0080_2002;
    exp_w[5] = 32'h0440_4000;
    exp_w[6] = 32'h0000_0800;
    exp_w[7] = 32'h0000_0808;
    exp_w[8] = 32'h0000_0000;
    exp_w[9] = 32'h0001_0302;
`ifdef CFG_DISC_REGION_TABLE_EN
    exp_w[10] = 32'h0000_0000; exp_w[11] = 32'h0000_1000;
    exp_w[12] = 32'h0001_0000; exp_w[13] = 32'h0001_0000;
    exp_w[14] = 32'h8000_0000; exp_w[15] = 32'h4000_0000;
    exp_w[16] = 32'h0200_0000; exp_w[17] = 32'h000C_0000;
    exp_w[18] = 32'h0C00_0000; exp_w[19] = 32'h0400_0000;
    exp_w[20] = 32'h8000_0000; exp_w[21] = 32'h4000_0000;
`endif
    for (int i = 0; i < NW - 1; i++) exp_w[NW-1] = exp_w[NW-1] ^ exp_w[i];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("rst_rerr", 32'(bus.rerr_o), 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    chk("rst_dvalid", 32'(bus.dump_valid_o), 32'd0);
    chk("rst_dlast", 32'(bus.dump_last_o), 32'd0);
    chk("rst_dbusy", 32'(bus.dump_busy_o), 32'd0);
    chk("rst_ddata", bus.dump_data_o, 32'd0);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.rready_i = 1'b1;

    // Table reads
    do_read("rd_magic", 8'h00, 1'b0, 32'hC7A6_0001, 1'b0);
    do_read("rd_xlen",  8'h04, 1'b0, 32'h0000_0020, 1'b0);
    do_read("rd_feat",  8'h08, 1'b0, 32'h0000_0083, 1'b0);
    do_read("rd_queue", 8'h0C, 1'b0, 32'h0807_0202, 1'b0);
    do_read("rd_bpred", 8'h10, 1'b0, 32'h0080_2002, 1'b0);
    do_read("rd_axi",   8'h14, 1'b0, 32'h0440_4000, 1'b0);
    do_read("rd_halt",  8'h18, 1'b0, 32'h0000_0800, 1'b0);
    do_read("rd_exc",   8'h1C, 1'b0, 32'h0000_0808, 1'b0);
    do_read("rd_rules", 8'h24, 1'b0, 32'h0001_0302, 1'b0);
    do_read("rd_idx10", 8'h28, 1'b0, exp_w[10], 1'b0);
`ifdef CFG_DISC_REGION_TABLE_EN
    do_read("rd_idx11", 8'h2C, 1'b0, 32'h0000_1000, 1'b0);
    do_read("rd_csum",  8'h58, 1'b0, exp_w[22], 1'b0);
    do_read("rd_idx23", 8'h5C, 1'b0, 32'h0, 1'b1);
`else
    do_read("rd_idx11", 8'h2C, 1'b0, 32'h0, 1'b1);
    do_read("rd_idx22", 8'h58, 1'b0, 32'h0, 1'b1);
`endif
    do_read("err_write", 8'h04, 1'b1, 32'h0, 1'b1);
    do_read("err_misal", 8'h05, 1'b0, 32'h0, 1'b1);
    do_read("err_range", 8'h7C, 1'b0, 32'h0, 1'b1);

    // Back-pressure: two grants fill the buffer, third waits for a pop
    bus.rready_i = 1'b0;
    bus.req_i    = 1'b1;
    bus.addr_i   = 8'h04;
    @(negedge clk);
    chk("stall_gnt0", 32'(bus.gnt_o), 32'd1);
    @(posedge clk); #1;
    bus.addr_i = 8'h08;
    @(negedge clk);
    chk("stall_gnt1", 32'(bus.gnt_o), 32'd1);
    chk("stall_rvalid", 32'(bus.rvalid_o), 32'd1);
    chk("stall_data0", bus.rdata_o, 32'h0000_0020);
    @(posedge clk); #1;
    bus.addr_i = 8'h0C;
    @(negedge clk);
    chk("stall_full_gnt", 32'(bus.gnt_o), 32'd0);
    chk("stall_hold0", bus.rdata_o, 32'h0000_0020);
    @(posedge clk); #1;
    bus.rready_i = 1'b1;
    @(negedge clk);
    chk("stall_nobypass", 32'(bus.gnt_o), 32'd0);
    chk("stall_hold1", bus.rdata_o, 32'h0000_0020);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_gnt2", 32'(bus.gnt_o), 32'd1);
    chk("stall_data1", bus.rdata_o, 32'h0000_0083);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    @(negedge clk);
    chk("stall_rvalid2", 32'(bus.rvalid_o), 32'd1);
    chk("stall_data2", bus.rdata_o, 32'h0807_0202);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_empty", 32'(bus.rvalid_o), 32'd0);
    @(posedge clk); #1;

    // Dump with random sink back-pressure and a stray start mid-stream
    bus.dump_start_i = 1'b1;
    @(negedge clk);
    chk("dump_idle_busy", 32'(bus.dump_busy_o), 32'd0);
    @(posedge clk); #1;
    bus.dump_start_i = 1'b0;
    k    = 0;
    cyc  = 0;
    xacc = 32'h0;
    while (k < NW && cyc < 500) begin
      bus.dump_ready_i = 1'($urandom_range(0, 1));
      bus.dump_start_i = (k == 4);
      @(negedge clk);
      chk("dump_valid", 32'(bus.dump_valid_o), 32'd1);
      chk("dump_busy", 32'(bus.dump_busy_o), 32'd1);
      chk($sformatf("dump_data%0d", k), bus.dump_data_o, exp_w[k]);
      chk($sformatf("dump_last%0d", k), 32'(bus.dump_last_o), 32'(k == NW - 1));
      if (bus.dump_ready_i) begin
        if (k < NW - 1) xacc = xacc ^ bus.dump_data_o;
        else chk("dump_checksum", bus.dump_data_o, xacc);
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.dump_start_i = 1'b0;
    bus.dump_ready_i = 1'b1;
    chk("dump_count", 32'(k), 32'(NW));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dump_done_valid", 32'(bus.dump_valid_o), 32'd0);
      chk("dump_done_busy", 32'(bus.dump_busy_o), 32'd0);
      @(posedge clk); #1;
    end

    // Reset mid-dump with two responses pending
    bus.dump_ready_i = 1'b0;
    bus.dump_start_i = 1'b1;
    bus.rready_i     = 1'b0;
    bus.req_i        = 1'b1;
    bus.addr_i       = 8'h00;
    @(posedge clk); #1;
    bus.dump_start_i = 1'b0;
    bus.addr_i       = 8'h04;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_rvalid", 32'(bus.rvalid_o), 32'd1);
    chk("pre_rst_busy", 32'(bus.dump_busy_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("mid_rst_rdata", bus.rdata_o, 32'd0);
    chk("mid_rst_dvalid", 32'(bus.dump_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.dump_busy_o), 32'd0);
    chk("mid_rst_ddata", bus.dump_data_o, 32'd0);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.rready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", 32'(bus.rvalid_o), 32'd0);
    chk("post_rst_busy", 32'(bus.dump_busy_o), 32'd0);
    @(posedge clk); #1;
    do_read("post_rst_rd", 8'h08, 1'b0, 32'h0000_0083, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end
endmodule
